iq_framer: RTL and testbench



---
 rtl/iq_framer_if.sv | 32 +++
 rtl/iq_framer.sv | 125 ++++++++++++
 tb/tb_iq_framer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_framer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : iq_framer_if
// Brief    : Sample-in / packed-word-out bundle for the IQ framer.
// Revision : 1.0 - initial release
// ============================================================================
interface iq_framer_if #(
    parameter int IW = 12
);
    logic          enable;
    logic          mode;
    logic [IW-1:0] rx_i;
    logic [IW-1:0] rx_q;
    logic          rx_valid;
    logic [31:0]   Sin;
    logic          Ien;
    logic          sync;
    logic [31:0]   wcnt;
    logic [15:0]   drop_cnt;

    modport master (
        output enable, mode, rx_i, rx_q, rx_valid,
        input  Sin, Ien, sync, wcnt, drop_cnt
    );

    modport slave (
        input  enable, mode, rx_i, rx_q, rx_valid,
        output Sin, Ien, sync, wcnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/iq_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : iq_framer
// Brief    : Packs I/Q samples into 32-bit stream words (wide or narrow mode).
// Revision : 1.0 - initial release
// ============================================================================
module iq_framer #(
    parameter int IW = 12
) (
    input  wire logic   Sclk,
    input  wire logic   rst,
    iq_framer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_mode;
    logic        r_pend;
    logic [7:0]  r_hold_i;
    logic [7:0]  r_hold_q;
    logic [31:0] r_sin;
    logic        r_ien;
    logic [31:0] r_wcnt;
    logic [15:0] r_drop;

    logic        w_sync;
    logic        w_accept;
    logic        w_flush;
    logic [31:0] w_wide;
    logic [31:0] w_pair;
    logic [31:0] w_pad;

    always_comb begin
        w_next_state = r_state;
        w_sync       = 1'b0;
        w_accept     = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.enable) begin
                    w_next_state = S_RUN;
                    w_sync       = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.enable) begin
                    // Padded word is loaded on entry so Ien is high during FLUSH
                    w_next_state = r_pend ? S_FLUSH : S_IDLE;
                    w_flush      = r_pend;
                end else begin
                    w_accept = bus.rx_valid;
                end
            end
            S_FLUSH: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_wide = {16'($signed(bus.rx_q)), 16'($signed(bus.rx_i))};
    assign w_pair = {bus.rx_q[IW-1 -: 8], bus.rx_i[IW-1 -: 8], r_hold_q, r_hold_i};
    assign w_pad  = {16'h0000, r_hold_q, r_hold_i};

    always_ff @(posedge Sclk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_pend   <= 1'b0;
            r_hold_i <= 8'h00;
            r_hold_q <= 8'h00;
            r_sin    <= 32'h0;
            r_ien    <= 1'b0;
            r_wcnt   <= 32'h0;
            r_drop   <= 16'h0;
        end else begin
            r_state <= w_next_state;
            r_ien   <= 1'b0;

            if (w_sync) begin
                r_mode <= bus.mode;
                r_wcnt <= 32'h0;
            end else if (r_ien) begin
                r_wcnt <= r_wcnt + 32'd1;
            end

            if (w_accept) begin
                if (!r_mode) begin
                    r_sin <= w_wide;
                    r_ien <= 1'b1;
                end else if (r_pend) begin
                    r_sin  <= w_pair;
                    r_ien  <= 1'b1;
                    r_pend <= 1'b0;
                end else begin
                    r_hold_i <= bus.rx_i[IW-1 -: 8];
                    r_hold_q <= bus.rx_q[IW-1 -: 8];
                    r_pend   <= 1'b1;
                end
            end else if (w_flush) begin
                r_sin  <= w_pad;
                r_ien  <= 1'b1;
                r_pend <= 1'b0;
            end

            if (bus.rx_valid && !w_accept && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    // sync is decoded from IDLE so it fires on the first cycle out of reset
    assign bus.sync     = w_sync & ~rst;
    assign bus.Sin      = r_sin;
    assign bus.Ien      = r_ien;
    assign bus.wcnt     = r_wcnt;
    assign bus.drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_iq_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_iq_framer
// Brief    : Scoreboard bench for iq_framer (wide/narrow packing, flush, drops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_framer;

    localparam int IW = 12;

    logic clk;
    logic rst;

    iq_framer_if #(.IW(IW)) bus ();

    iq_framer #(.IW(IW)) dut (
        .Sclk (clk),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int sync_cnt = 0, overlap = 0, early = 0, hold_err = 0, since_sync = 100;
    bit first_pending = 1'b0;
    logic [31:0] prev_sin = 32'h0;

    // Monitor: collects emitted words and tracks output-protocol invariants
    always @(negedge clk) begin
        if (bus.Ien === 1'b1) got_q.push_back(bus.Sin);
        if (bus.sync === 1'b1 && bus.Ien === 1'b1) overlap++;
        if (bus.sync === 1'b1) begin
            sync_cnt++;
            since_sync    = 0;
            first_pending = 1'b1;
        end else begin
            since_sync++;
        end
        if (bus.Ien === 1'b1 && first_pending) begin
            if (since_sync < 2) early++;
            first_pending = 1'b0;
        end
        if (!rst && bus.Ien !== 1'b1 && bus.Sin !== prev_sin) hold_err++;
        prev_sin = bus.Sin;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [IW-1:0] i, input logic [IW-1:0] q);
        bus.rx_i     = i;
        bus.rx_q     = q;
        bus.rx_valid = 1'b1;
    endtask

    task automatic start_stream(input logic md);
        bus.enable   = 1'b0;
        bus.rx_valid = 1'b0;
        tick();
        tick();
        bus.enable = 1'b1;
        bus.mode   = md;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable = 1'b1; bus.mode = 1'b1;
        sample(12'h7FF, 12'h800);
        tick(); tick(); tick();
        @(negedge clk);
        n_tests++; if (bus.Sin !== 32'h0) begin n_fail++; $display("FAIL reset_sin got %h exp 0", bus.Sin); end
        n_tests++; if (bus.Ien !== 1'b0) begin n_fail++; $display("FAIL reset_ien got %b exp 0", bus.Ien); end
        n_tests++; if (bus.sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync got %b exp 0", bus.sync); end
        n_tests++; if (bus.wcnt !== 32'h0) begin n_fail++; $display("FAIL reset_wcnt got %0d exp 0", bus.wcnt); end
        n_tests++; if (bus.drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", bus.drop_cnt); end
        bus.rx_valid = 1'b0;
        got_q.delete();
    endtask

    task automatic test_wide();
        logic [31:0] e, g;
        tick();
        rst = 1'b0; bus.enable = 1'b1; bus.mode = 1'b0; bus.rx_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.sync !== 1'b1) begin n_fail++; $display("FAIL wide_sync0 got %b exp 1", bus.sync); end
        tick();
        for (int k = 0; k < 4; k++) begin
            sample(12'h7FF, 12'h800);
            exp_q.push_back(32'hF800_07FF);
            tick();
        end
        bus.rx_valid = 1'b0;
        tick(); tick(); tick();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wide_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL wide_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
        @(negedge clk);
        n_tests++; if (bus.wcnt !== 32'd4) begin n_fail++; $display("FAIL wide_wcnt got %0d exp 4", bus.wcnt); end
        tick();
        bus.enable = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        n_tests++; if (bus.wcnt !== 32'd4) begin n_fail++; $display("FAIL idle_wcnt_hold got %0d exp 4", bus.wcnt); end
        tick();
    endtask

    task automatic test_narrow();
        logic [31:0] e, g;
        int s0;
        s0 = sync_cnt;
        start_stream(1'b1);
        sample(12'h120, 12'h340); tick();
        sample(12'h560, 12'h780); exp_q.push_back(32'h7856_3412); tick();
        bus.rx_valid = 1'b0;
        tick(); tick();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL narrow_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL narrow_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
        @(negedge clk);
        n_tests++; if (bus.wcnt !== 32'd1) begin n_fail++; $display("FAIL narrow_wcnt got %0d exp 1", bus.wcnt); end
        n_tests++; if (sync_cnt !== s0 + 1) begin n_fail++; $display("FAIL narrow_syncs got %0d exp %0d", sync_cnt - s0, 1); end
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] e, g;
        start_stream(1'b1);
        sample(12'hAB0, 12'hCD0); exp_q.push_back(32'h0000_CDAB); tick();
        bus.rx_valid = 1'b0; bus.enable = 1'b0;
        tick();
        @(negedge clk);
        n_tests++; if (bus.Ien !== 1'b1 || bus.Sin !== 32'h0000_CDAB) begin n_fail++; $display("FAIL flush_word got ien=%b sin=%h exp ien=1 sin=0000cdab", bus.Ien, bus.Sin); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.Ien !== 1'b0 || bus.Sin !== 32'h0000_CDAB) begin n_fail++; $display("FAIL flush_after got ien=%b sin=%h exp ien=0 sin=0000cdab", bus.Ien, bus.Sin); end
        tick();
        bus.enable = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.sync !== 1'b1) begin n_fail++; $display("FAIL flush_idle_sync got %b exp 1", bus.sync); end
        tick(); tick(); tick();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL flush_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL flush_sb got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_drop();
        rst = 1'b1; bus.rx_valid = 1'b0;
        tick(); tick();
        rst = 1'b0; bus.enable = 1'b1; bus.mode = 1'b0;
        tick();
        tick();
        bus.enable = 1'b0; sample(12'h111, 12'h222);
        tick();
        for (int k = 0; k < 3; k++) begin
            sample(12'h333, 12'h444);
            tick();
        end
        bus.rx_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_tests++; if (bus.drop_cnt !== 16'd4) begin n_fail++; $display("FAIL drop_cnt got %0d exp 4", bus.drop_cnt); end
        n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL drop_no_ien got %0d words exp 0", got_q.size()); end
        got_q.delete();
        tick();
    endtask

    task automatic test_mode_toggle();
        logic [31:0] e, g;
        start_stream(1'b0);
        sample(12'h123, 12'hFED); exp_q.push_back(32'hFFED_0123); tick();
        bus.mode = 1'b1;
        sample(12'h234, 12'hECB); exp_q.push_back(32'hFECB_0234); tick();
        sample(12'h7FF, 12'h001); exp_q.push_back(32'h0001_07FF); tick();
        bus.rx_valid = 1'b0;
        start_stream(1'b1);
        sample(12'hA50, 12'hB60); tick();
        bus.mode = 1'b0;
        sample(12'hC70, 12'hD80); exp_q.push_back(32'hD8C7_B6A5); tick();
        bus.rx_valid = 1'b0;
        tick(); tick();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL toggle_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL toggle_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_midrun();
        logic [31:0] e, g;
        start_stream(1'b1);
        sample(12'h110, 12'h220); tick();
        bus.rx_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.sync !== 1'b0) begin n_fail++; $display("FAIL rst_sync_gate got %b exp 0", bus.sync); end
        tick(); tick();
        @(negedge clk);
        n_tests++; if (bus.Sin !== 32'h0 || bus.Ien !== 1'b0 || bus.sync !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs got sin=%h ien=%b sync=%b exp 0", bus.Sin, bus.Ien, bus.sync); end
        n_tests++; if (bus.wcnt !== 32'h0 || bus.drop_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_mid_cnts got wcnt=%0d drop=%0d exp 0", bus.wcnt, bus.drop_cnt); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.sync !== 1'b1) begin n_fail++; $display("FAIL rst_release_sync got %b exp 1", bus.sync); end
        tick();
        sample(12'h990, 12'hAA0); tick();
        sample(12'hBB0, 12'hCC0); exp_q.push_back(32'hCCBB_AA99); tick();
        bus.rx_valid = 1'b0;
        tick(); tick();
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_mid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL rst_mid_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, g;
        int s0;
        s0 = sync_cnt;
        start_stream(1'b1);
        sample(12'h120, 12'h340); exp_q.push_back(32'h0000_3412); tick();
        bus.rx_valid = 1'b0; bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.Ien !== 1'b1 || bus.Sin !== 32'h0000_3412 || bus.sync !== 1'b0) begin n_fail++; $display("FAIL b2b_flush got ien=%b sin=%h sync=%b exp 1/00003412/0", bus.Ien, bus.Sin, bus.sync); end
        tick();
        @(negedge clk);
        n_tests++; if (bus.sync !== 1'b1 || bus.Ien !== 1'b0) begin n_fail++; $display("FAIL b2b_resync got sync=%b ien=%b exp 1/0", bus.sync, bus.Ien); end
        tick(); tick(); tick();
        n_tests++; if (sync_cnt !== s0 + 2) begin n_fail++; $display("FAIL b2b_syncs got %0d exp 2", sync_cnt - s0); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_word got %h exp %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_invariants();
        n_tests++; if (overlap !== 0) begin n_fail++; $display("FAIL sync_ien_overlap got %0d exp 0", overlap); end
        n_tests++; if (early !== 0) begin n_fail++; $display("FAIL ien_too_early got %0d exp 0", early); end
        n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL sin_hold got %0d changes exp 0", hold_err); end
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0; bus.mode = 1'b0;
        bus.rx_i = '0; bus.rx_q = '0; bus.rx_valid = 1'b0;
        test_reset();
        test_wide();
        test_narrow();
        test_flush();
        test_drop();
        test_mode_toggle();
        test_reset_midrun();
        test_back_to_back();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
